distance_match_bank: RTL and testbench
======================================

// Module: distance_match_bank
// PURPOSE
//  Parametrised template matcher for the MFCC recogniser. Computes squared Euclidean distance
//  between one feature vector and N_TPL stored templates over DIM coefficients. Coefficients are
//  streamed one index per cycle; all templates accumulate in parallel. A sequential argmin pass
//  then reports the best-matching template. Sits between the MFCC feature store and the decision logic.
// PARAMETERS
//  N_TPL   16  number of templates (>=2)
//  DIM     13  coefficients per vector (>=1)
//  DW      14  coefficient width, two's complement
//  ACC_W   32  accumulator/distance width, unsigned, saturating
//  IDX_W   5   width of coef_idx and best_idx; 2^IDX_W >= max(DIM,N_TPL)
// PORTS
//  clk        in   1            clock, all logic rising-edge
//  rst_n      in   1            asynchronous active-low reset
//  start      in   1            request a match; accepted only in IDLE
//  busy       out  1            high from the cycle after acceptance until finish inclusive
//  finish     out  1            one-cycle pulse; results valid from this cycle
//  coef_idx   out  IDX_W        coefficient address to feature and template stores
//  feat_data  in   DW           feature coefficient, valid 1 cycle after coef_idx
//  tpl_data   in   N_TPL*DW     packed template coefficients (template t at [t*DW +: DW]), same timing
//  dist_data  out  N_TPL*ACC_W  packed distances (template t at [t*ACC_W +: ACC_W])
//  dist_sat   out  N_TPL        per-template saturation flag
//  best_idx   out  IDX_W        index of minimum distance
//  best_dist  out  ACC_W        minimum distance value
// BEHAVIOUR
//  Reset: state IDLE; busy, finish, coef_idx, dist_data, dist_sat, best_idx, best_dist all 0.
//  FSM: IDLE -> FETCH -> DRAIN -> CMP -> DONE -> IDLE.
//   IDLE : start=1 -> FETCH; all accumulators and dist_sat cleared on acceptance.
//   FETCH: DIM cycles; coef_idx = 0,1,..,DIM-1 in successive cycles; internal rd_vld = FETCH delayed 1.
//   DRAIN: 1 cycle; absorbs the last returned coefficient; coef_idx holds DIM-1.
//   CMP  : N_TPL cycles; cycle k compares template k against running min.
//   DONE : 1 cycle; finish=1; best_idx, best_dist and dist_data update in this cycle; -> IDLE.
//  Latency: start sampled high at edge 0 -> finish high in cycle DIM+N_TPL+2 (31 with defaults).
//  Arithmetic per rd_vld cycle, per template t: diff = tpl - feat, sign-extended to DW+1 bits;
//   sq = diff*diff, unsigned, 2*DW+2 bits; acc_t += sq, clamped at 2^ACC_W-1.
//   dist_sat[t] sets on clamp and is sticky until the next accepted start.
//  Argmin: init min = acc_0, idx = 0; update only on strict less-than, so the lowest index wins ties.
//  Outputs: dist_data, best_* and dist_sat are registered and hold until the next DONE.
//   Intermediate accumulator values are never visible on the output ports.
//  start while busy: ignored, no effect on the current run. start held high: a new run is
//   accepted in the IDLE cycle after DONE, giving back-to-back runs.
//  rst_n low mid-run: immediate return to IDLE with all outputs 0; no finish pulse is issued.
//  feat_data and tpl_data are ignored outside rd_vld cycles.
// TESTING
//  1 Identical vectors: feature = template 5 = all coefs 100; other templates = 0
//    -> dist_5 = 0, others = 13*10000 = 130000; best_idx = 5, best_dist = 0; finish in cycle 31.
//  2 Tie: templates 3 and 9 both at distance 52, all others larger -> best_idx = 3.
//  3 Extremes with ACC_W = 16: feat = -8192, tpl = 8191 -> per-coef sq = 268402689;
//    acc saturates to 65535, dist_sat = 1; with ACC_W = 32 -> 13*268402689 = 3489234957, dist_sat = 0.
//  4 start pulsed at cycle 10 of a run -> ignored; exactly one finish; results match a single run.
//  5 rst_n asserted in CMP -> all outputs 0 next cycle, no finish; a following start gives correct results.
//  6 Sweep N_TPL = 4, DIM = 1: random vectors vs. reference model; latency 1+4+2 = 7; coef_idx stays 0.

Source files
------------

// File: rtl/distance_match_bank.sv
// distance_match_bank: squared-Euclidean template matcher with sequential argmin
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start_i       request a match, accepted only when idle
//   busy_o        high from the cycle after acceptance through the finish cycle
//   finish_o      one-cycle pulse, results valid from this cycle
//   coef_idx_o    coefficient address to the feature and template stores
//   feat_data_i   feature coefficient, valid one cycle after coef_idx_o
//   tpl_data_i    packed template coefficients, template t at [t*DW +: DW]
//   dist_data_o   packed distances, template t at [t*ACC_W +: ACC_W]
//   dist_sat_o    per-template saturation flags
//   best_idx_o    index of the minimum distance (lowest index on ties)
//   best_dist_o   minimum distance value
module distance_match_bank #(
    parameter int N_TPL = 16,
    parameter int DIM   = 13,
    parameter int DW    = 14,
    parameter int ACC_W = 32,
    parameter int IDX_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   finish_o,
    output logic [IDX_W-1:0]       coef_idx_o,
    input  logic [DW-1:0]          feat_data_i,
    input  logic [N_TPL*DW-1:0]    tpl_data_i,
    output logic [N_TPL*ACC_W-1:0] dist_data_o,
    output logic [N_TPL-1:0]       dist_sat_o,
    output logic [IDX_W-1:0]       best_idx_o,
    output logic [ACC_W-1:0]       best_dist_o
);
    localparam int SQ_W  = 2*DW+2;
    localparam int SUM_W = (ACC_W > SQ_W ? ACC_W : SQ_W) + 1;
    localparam logic [IDX_W-1:0] DIM_LAST = IDX_W'(DIM-1);
    localparam logic [IDX_W-1:0] TPL_LAST = IDX_W'(N_TPL-1);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CMP, DONE} state_t;
    state_t state_q, state_d;
    logic [IDX_W-1:0] coef_idx_q, coef_idx_d, cnt_q, cnt_d, min_idx_q, min_idx_d, best_idx_q;
    logic [ACC_W-1:0] min_q, min_d, best_dist_q, cand;
    logic [N_TPL*ACC_W-1:0] acc_flat, dist_q;
    logic [N_TPL-1:0] sat_flat, dist_sat_q;
    logic rd_vld_q, accept, cmp_last;
    assign accept     = state_q == IDLE && start_i;
    assign cmp_last   = state_q == CMP && cnt_q == TPL_LAST;
    assign busy_o     = state_q != IDLE;
    assign finish_o   = state_q == DONE;
    assign coef_idx_o = coef_idx_q;
    assign dist_data_o = dist_q;
    assign dist_sat_o  = dist_sat_q;
    assign best_idx_o  = best_idx_q;
    assign best_dist_o = best_dist_q;
    always_comb begin
        state_d    = state_q;
        coef_idx_d = coef_idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d    = FETCH;
                coef_idx_d = '0;
            end
            FETCH: if (coef_idx_q == DIM_LAST) state_d = DRAIN;
                   else coef_idx_d = coef_idx_q + IDX_W'(1);
            DRAIN: begin
                state_d = CMP;
                cnt_d   = '0;
            end
            CMP: if (cnt_q == TPL_LAST) state_d = DONE;
                 else cnt_d = cnt_q + IDX_W'(1);
            default: state_d = IDLE;
        endcase
    end
    // Running minimum: the first compare seeds it, later ones replace only on strict less-than.
    always_comb begin
        cand = '0;
        for (int k = 0; k < N_TPL; k++) if (cnt_q == IDX_W'(k)) cand = acc_flat[k*ACC_W +: ACC_W];
        min_d     = (cnt_q == '0 || cand < min_q) ? cand : min_q;
        min_idx_d = (cnt_q == '0 || cand < min_q) ? cnt_q : min_idx_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            coef_idx_q  <= '0;
            cnt_q       <= '0;
            rd_vld_q    <= 1'b0;
            min_q       <= '0;
            min_idx_q   <= '0;
            dist_q      <= '0;
            dist_sat_q  <= '0;
            best_idx_q  <= '0;
            best_dist_q <= '0;
        end else begin
            state_q    <= state_d;
            coef_idx_q <= coef_idx_d;
            cnt_q      <= cnt_d;
            rd_vld_q   <= state_q == FETCH;
            if (state_q == CMP) begin
                min_q     <= min_d;
                min_idx_q <= min_idx_d;
            end
            // Results land on the ports only once, entering DONE.
            if (cmp_last) begin
                dist_q      <= acc_flat;
                dist_sat_q  <= sat_flat;
                best_idx_q  <= min_idx_d;
                best_dist_q <= min_d;
            end
        end
    end
    for (genvar t = 0; t < N_TPL; t++) begin : g_tpl
        logic [DW:0] diff, mag;
        logic [SQ_W-1:0] sq;
        logic [SUM_W-1:0] sum;
        logic [ACC_W-1:0] acc_q;
        logic sat_q, ovf;
        // Magnitude of the DW+1-bit difference is at most 2^DW, so it fits unsigned in DW+1 bits.
        always_comb begin
            diff = {tpl_data_i[t*DW+DW-1], tpl_data_i[t*DW +: DW]} - {feat_data_i[DW-1], feat_data_i};
            mag  = diff[DW] ? -diff : diff;
            sq   = SQ_W'(mag) * SQ_W'(mag);
            sum  = SUM_W'(acc_q) + SUM_W'(sq);
            ovf  = |sum[SUM_W-1:ACC_W];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (accept) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (rd_vld_q) begin
                acc_q <= ovf ? '1 : sum[ACC_W-1:0];
                sat_q <= sat_q | ovf;
            end
        end
        assign acc_flat[t*ACC_W +: ACC_W] = acc_q;
        assign sat_flat[t] = sat_q;
    end
endmodule

// File: tb/tb_distance_match_bank.sv
// tb_distance_match_bank: randomized self-checking bench against a behavioural distance/argmin model
module tb_distance_match_bank;
    localparam int N = 16, D = 13, DW = 14, N2 = 4;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
    logic busy0, fin0, busy1, fin1, busy2, fin2;
    logic [4:0] ci0, ci1, ci2, bi0, bi1, bi2;
    logic [DW-1:0] feat_q, feat2_q;
    logic [N*DW-1:0] tpl_q;
    logic [N2*DW-1:0] tpl2_q;
    logic [N*32-1:0] dd0;
    logic [N*16-1:0] dd1;
    logic [N2*32-1:0] dd2;
    logic [N-1:0] ds0, ds1;
    logic [N2-1:0] ds2;
    logic [31:0] bd0, bd2;
    logic [15:0] bd1;
    int fm [D];
    int tm [N][D];
    longint exp_dist [N];
    bit exp_sat [N];
    int exp_bi;
    longint exp_bd;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    // Synchronous-read stores: data appears one cycle after the address.
    always @(posedge clk) begin
        feat_q <= DW'(ci0 < D ? fm[ci0] : 0);
        for (int t = 0; t < N; t++) tpl_q[t*DW +: DW] <= DW'(ci0 < D ? tm[t][ci0] : 0);
        feat2_q <= DW'(fm[0]);
        for (int t = 0; t < N2; t++) tpl2_q[t*DW +: DW] <= DW'(tm[t][0]);
    end

    distance_match_bank u0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy0), .finish_o(fin0),
        .coef_idx_o(ci0), .feat_data_i(feat_q), .tpl_data_i(tpl_q), .dist_data_o(dd0),
        .dist_sat_o(ds0), .best_idx_o(bi0), .best_dist_o(bd0));
    distance_match_bank #(.ACC_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy1), .finish_o(fin1),
        .coef_idx_o(ci1), .feat_data_i(feat_q), .tpl_data_i(tpl_q), .dist_data_o(dd1),
        .dist_sat_o(ds1), .best_idx_o(bi1), .best_dist_o(bd1));
    distance_match_bank #(.N_TPL(N2), .DIM(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .busy_o(busy2), .finish_o(fin2),
        .coef_idx_o(ci2), .feat_data_i(feat2_q), .tpl_data_i(tpl2_q), .dist_data_o(dd2),
        .dist_sat_o(ds2), .best_idx_o(bi2), .best_dist_o(bd2));

    function automatic int rnd(input int r);
        return int'($urandom_range(0, 2*r-1)) - r;
    endfunction

    // Reference: plain sum of squared differences, clamped, then lowest-index minimum.
    task automatic model(input int n, input int d, input int aw);
        longint mx, s;
        mx = (longint'(1) << aw) - 1;
        exp_bi = 0;
        for (int t = 0; t < n; t++) begin
            s = 0;
            exp_sat[t] = 0;
            for (int i = 0; i < d; i++) begin
                s += longint'(tm[t][i] - fm[i]) * longint'(tm[t][i] - fm[i]);
                if (s > mx) begin
                    s = mx;
                    exp_sat[t] = 1;
                end
            end
            exp_dist[t] = s;
            if (s < exp_dist[exp_bi]) exp_bi = t;
        end
        exp_bd = exp_dist[exp_bi];
    endtask

    task automatic fill(input int r);
        for (int i = 0; i < D; i++) fm[i] = rnd(r);
        for (int t = 0; t < N; t++) for (int i = 0; i < D; i++) tm[t][i] = rnd(r);
    endtask

    // Starts one run on u0/u1 from an idle negedge and returns in the finish cycle.
    // bad counts cycles where busy dropped, coef_idx was off, or outputs moved early.
    task automatic run_a(input int pulse_at, output int lat, output int bad);
        logic [N*32-1:0] snap;
        snap = dd0;
        bad = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (fin0 !== 1'b1 && lat < 200) begin
            if (busy0 !== 1'b1 || dd0 !== snap) bad++;
            if (lat <= D + 1 && ci0 !== 5'(lat - 1 < D - 1 ? lat - 1 : D - 1)) bad++;
            start = (lat == pulse_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, fin0, ci0, bi0, bd0} !== '0) begin
            errors++;
            $display("FAIL reset ctl busy %b fin %b idx %0d best %0d/%0d want all 0", busy0, fin0, ci0, bi0, bd0);
        end
        checks++;
        if (dd0 !== '0 || ds0 !== '0) begin
            errors++;
            $display("FAIL reset data dist %h sat %h want 0", dd0, ds0);
        end
        checks++;
        if ({busy2, fin2, ci2, bi2, bd2, dd2, ds2} !== '0) begin
            errors++;
            $display("FAIL reset small instance outputs nonzero want 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identical;
        int lat, bad;
        for (int i = 0; i < D; i++) fm[i] = 100;
        for (int t = 0; t < N; t++) for (int i = 0; i < D; i++) tm[t][i] = (t == 5) ? 100 : 0;
        model(N, D, 32);
        run_a(0, lat, bad);
        checks++;
        if (lat !== 31 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL ident latency got %0d busy %b want 31 busy 1", lat, busy0);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ident protocol got %0d bad cycles want 0", bad);
        end
        for (int t = 0; t < N; t++) begin
            checks++;
            if (dd0[t*32 +: 32] !== 32'(exp_dist[t]) || ds0[t] !== exp_sat[t]) begin
                errors++;
                $display("FAIL ident dist[%0d] got %0d sat %b want %0d sat %b", t, dd0[t*32 +: 32], ds0[t], exp_dist[t], exp_sat[t]);
            end
        end
        checks++;
        if (bi0 !== 5'd5 || bd0 !== 32'd0 || dd0[0 +: 32] !== 32'd130000) begin
            errors++;
            $display("FAIL ident best got %0d/%0d dist0 %0d want 5/0 dist0 130000", bi0, bd0, dd0[0 +: 32]);
        end
        @(negedge clk);
        checks++;
        if (fin0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL ident after-done got fin %b busy %b want 0 0", fin0, busy0);
        end
    endtask

    task automatic test_tie;
        int lat, bad;
        for (int i = 0; i < D; i++) fm[i] = rnd(1000);
        for (int t = 0; t < N; t++)
            for (int i = 0; i < D; i++)
                tm[t][i] = fm[i] + ((t == 3 || t == 9) ? 0 : (i == 0 ? 8 : int'($urandom_range(0, 3))));
        tm[3][0] += 6;
        tm[3][1] += 4;
        tm[9][0] -= 4;
        tm[9][1] -= 6;
        model(N, D, 32);
        run_a(0, lat, bad);
        checks++;
        if (bi0 !== 5'd3 || bd0 !== 32'd52) begin
            errors++;
            $display("FAIL tie best got %0d/%0d want 3/52", bi0, bd0);
        end
        for (int t = 0; t < N; t++) begin
            checks++;
            if (dd0[t*32 +: 32] !== 32'(exp_dist[t])) begin
                errors++;
                $display("FAIL tie dist[%0d] got %0d want %0d", t, dd0[t*32 +: 32], exp_dist[t]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, bad;
        for (int it = 0; it < 6; it++) begin
            fill(it % 2 == 1 ? 8192 : 40);
            run_a(0, lat, bad);
            checks++;
            if (lat !== 31 || bad !== 0) begin
                errors++;
                $display("FAIL random[%0d] latency got %0d bad %0d want 31 bad 0", it, lat, bad);
            end
            model(N, D, 32);
            for (int t = 0; t < N; t++) begin
                checks++;
                if (dd0[t*32 +: 32] !== 32'(exp_dist[t]) || ds0[t] !== exp_sat[t]) begin
                    errors++;
                    $display("FAIL random[%0d] acc32 dist[%0d] got %0d sat %b want %0d sat %b", it, t, dd0[t*32 +: 32], ds0[t], exp_dist[t], exp_sat[t]);
                end
            end
            checks++;
            if (bi0 !== 5'(exp_bi) || bd0 !== 32'(exp_bd)) begin
                errors++;
                $display("FAIL random[%0d] acc32 best got %0d/%0d want %0d/%0d", it, bi0, bd0, exp_bi, exp_bd);
            end
            model(N, D, 16);
            for (int t = 0; t < N; t++) begin
                checks++;
                if (dd1[t*16 +: 16] !== 16'(exp_dist[t]) || ds1[t] !== exp_sat[t]) begin
                    errors++;
                    $display("FAIL random[%0d] acc16 dist[%0d] got %0d sat %b want %0d sat %b", it, t, dd1[t*16 +: 16], ds1[t], exp_dist[t], exp_sat[t]);
                end
            end
            checks++;
            if (bi1 !== 5'(exp_bi) || bd1 !== 16'(exp_bd) || fin1 !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d] acc16 best got %0d/%0d fin %b want %0d/%0d fin 1", it, bi1, bd1, fin1, exp_bi, exp_bd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_extremes;
        int lat, bad;
        for (int i = 0; i < D; i++) fm[i] = -8192;
        for (int t = 0; t < N; t++) for (int i = 0; i < D; i++) tm[t][i] = (t == 7) ? 8190 : 8191;
        run_a(0, lat, bad);
        checks++;
        if (dd0[0 +: 32] !== 32'd3489234957 || ds0 !== '0) begin
            errors++;
            $display("FAIL extremes acc32 got dist0 %0d sat %h want 3489234957 sat 0", dd0[0 +: 32], ds0);
        end
        model(N, D, 32);
        checks++;
        if (bi0 !== 5'(exp_bi) || bd0 !== 32'(exp_bd)) begin
            errors++;
            $display("FAIL extremes acc32 best got %0d/%0d want %0d/%0d", bi0, bd0, exp_bi, exp_bd);
        end
        checks++;
        if (dd1 !== '1 || ds1 !== '1 || bi1 !== 5'd0 || bd1 !== 16'hffff) begin
            errors++;
            $display("FAIL extremes acc16 got dist %h sat %h best %0d/%0d want all 65535 sat all 0/65535", dd1, ds1, bi1, bd1);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int lat, bad, nfin;
        fill(300);
        model(N, D, 32);
        run_a(10, lat, bad);
        checks++;
        if (lat !== 31 || bad !== 0) begin
            errors++;
            $display("FAIL busy-start latency got %0d bad %0d want 31 bad 0", lat, bad);
        end
        for (int t = 0; t < N; t++) begin
            checks++;
            if (dd0[t*32 +: 32] !== 32'(exp_dist[t])) begin
                errors++;
                $display("FAIL busy-start dist[%0d] got %0d want %0d", t, dd0[t*32 +: 32], exp_dist[t]);
            end
        end
        checks++;
        if (bi0 !== 5'(exp_bi) || bd0 !== 32'(exp_bd)) begin
            errors++;
            $display("FAIL busy-start best got %0d/%0d want %0d/%0d", bi0, bd0, exp_bi, exp_bd);
        end
        nfin = 0;
        repeat (40) begin
            @(negedge clk);
            if (fin0 === 1'b1 || busy0 === 1'b1) nfin++;
        end
        checks++;
        if (nfin !== 0) begin
            errors++;
            $display("FAIL busy-start extra activity got %0d busy/finish cycles want 0", nfin);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bad, nfin;
        fill(500);
        model(N, D, 32);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy0, fin0, ci0, bi0, bd0} !== '0 || dd0 !== '0 || ds0 !== '0) begin
            errors++;
            $display("FAIL midreset outputs got busy %b fin %b idx %0d best %0d/%0d dist0 %0d want all 0", busy0, fin0, ci0, bi0, bd0, dd0[0 +: 32]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nfin = 0;
        repeat (40) begin
            @(negedge clk);
            if (fin0 === 1'b1) nfin++;
        end
        checks++;
        if (nfin !== 0) begin
            errors++;
            $display("FAIL midreset stray finish got %0d want 0", nfin);
        end
        run_a(0, lat, bad);
        checks++;
        if (lat !== 31 || bad !== 0) begin
            errors++;
            $display("FAIL midreset rerun latency got %0d bad %0d want 31 bad 0", lat, bad);
        end
        for (int t = 0; t < N; t++) begin
            checks++;
            if (dd0[t*32 +: 32] !== 32'(exp_dist[t])) begin
                errors++;
                $display("FAIL midreset rerun dist[%0d] got %0d want %0d", t, dd0[t*32 +: 32], exp_dist[t]);
            end
        end
        checks++;
        if (bi0 !== 5'(exp_bi) || bd0 !== 32'(exp_bd)) begin
            errors++;
            $display("FAIL midreset rerun best got %0d/%0d want %0d/%0d", bi0, bd0, exp_bi, exp_bd);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int c, f1, f2;
        fill(200);
        model(N, D, 32);
        start = 1'b1;
        c = 0;
        f1 = 0;
        f2 = 0;
        while (f2 == 0 && c < 200) begin
            @(negedge clk);
            c++;
            if (f1 != 0 && c == f1 + 1) begin
                checks++;
                if (busy0 !== 1'b0 || fin0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b idle gap got busy %b fin %b want 0 0", busy0, fin0);
                end
            end
            if (fin0 === 1'b1) begin
                checks++;
                if (bi0 !== 5'(exp_bi) || bd0 !== 32'(exp_bd) || dd0[N*32-1 -: 32] !== 32'(exp_dist[N-1])) begin
                    errors++;
                    $display("FAIL b2b run%0d best got %0d/%0d last %0d want %0d/%0d last %0d", f1 == 0 ? 1 : 2, bi0, bd0, dd0[N*32-1 -: 32], exp_bi, exp_bd, exp_dist[N-1]);
                end
                if (f1 == 0) begin
                    f1 = c;
                    fill(200);
                    model(N, D, 32);
                end else begin
                    f2 = c;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (f1 !== 31 || f2 - f1 !== 32) begin
            errors++;
            $display("FAIL b2b timing got finishes at %0d and %0d want 31 and 63", f1, f2);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b trailing run got busy %b want 0", busy0);
        end
    endtask

    task automatic test_sweep;
        int lat, bad;
        for (int it = 0; it < 6; it++) begin
            fm[0] = rnd(it < 3 ? 8192 : 20);
            for (int t = 0; t < N2; t++) tm[t][0] = rnd(it < 3 ? 8192 : 20);
            if (it == 5) tm[3][0] = tm[1][0];
            model(N2, 1, 32);
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            lat = 1;
            bad = 0;
            while (fin2 !== 1'b1 && lat < 50) begin
                if (ci2 !== 5'd0 || busy2 !== 1'b1) bad++;
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 7 || bad !== 0 || ci2 !== 5'd0) begin
                errors++;
                $display("FAIL sweep[%0d] latency got %0d bad %0d idx %0d want 7 bad 0 idx 0", it, lat, bad, ci2);
            end
            for (int t = 0; t < N2; t++) begin
                checks++;
                if (dd2[t*32 +: 32] !== 32'(exp_dist[t]) || ds2[t] !== exp_sat[t]) begin
                    errors++;
                    $display("FAIL sweep[%0d] dist[%0d] got %0d want %0d", it, t, dd2[t*32 +: 32], exp_dist[t]);
                end
            end
            checks++;
            if (bi2 !== 5'(exp_bi) || bd2 !== 32'(exp_bd)) begin
                errors++;
                $display("FAIL sweep[%0d] best got %0d/%0d want %0d/%0d", it, bi2, bd2, exp_bi, exp_bd);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_tie();
        test_random();
        test_extremes();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
